seg_display_ctrl: RTL and testbench

Board-side companion to the pipelined CPU top level: it consumes the CPU's `pc_out` and selected-register output and shows either value on a 4-digit multiplexed seven-segment display. It also turns the noisy single-step push-button into a clean, debounced step clock for the pipeline. All logic runs on the fast board clock; the CPU is clocked from `step_level`.

---
 rtl/seg_display_ctrl.sv | 131 +++++++++++++
 tb/tb_seg_display_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: debounced single-step clock for the pipelined CPU plus a
// 4-digit multiplexed seven-segment viewer for pc_in / reg_in.
// The value shown is latched once per frame, so the digits of one frame
// always come from a single 16-bit snapshot.
module seg_display_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REFRESH_CYCLES  = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_btn,
    input  logic        sel_pc,
    input  logic        half_sel,
    input  logic [31:0] pc_in,
    input  logic [31:0] reg_in,
    output logic        step_level,
    output logic        step_pulse,
    output logic [15:0] step_count,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RF_W = (REFRESH_CYCLES  > 2) ? $clog2(REFRESH_CYCLES)  : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_CYCLES - 1);

    logic            s1;
    logic            s2;
    logic [DB_W-1:0] db_cnt;
    logic            level_prev;
    logic [RF_W-1:0] rf_cnt;
    logic [1:0]      idx;
    logic [15:0]     frame;
    logic            frame_pc;
    logic [31:0]     src_word;
    logic [15:0]     src_half;
    logic [3:0]      nibble;

    // Active-low gfedcba pattern for one hex digit.
    function automatic logic [6:0] hex_code(input logic [3:0] v);
        logic [6:0] c;
        case (v)
            4'h0: c = 7'h40;
            4'h1: c = 7'h79;
            4'h2: c = 7'h24;
            4'h3: c = 7'h30;
            4'h4: c = 7'h19;
            4'h5: c = 7'h12;
            4'h6: c = 7'h02;
            4'h7: c = 7'h78;
            4'h8: c = 7'h00;
            4'h9: c = 7'h10;
            4'hA: c = 7'h08;
            4'hB: c = 7'h03;
            4'hC: c = 7'h46;
            4'hD: c = 7'h21;
            4'hE: c = 7'h06;
            default: c = 7'h0E;
        endcase
        return c;
    endfunction

    // Value that would be captured if a frame started this cycle, and the
    // nibble for the digit currently being scanned.
    always_comb begin
        src_word = sel_pc ? pc_in : reg_in;
        src_half = half_sel ? src_word[31:16] : src_word[15:0];
        nibble   = frame[{idx, 2'b00} +: 4];
    end

    // Rising edge of the debounced level; combinational so it is high in the
    // cycle right after step_level rises.
    assign step_pulse = step_level & ~level_prev;

    // Button synchroniser, debouncer, edge history and step counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            db_cnt     <= '0;
            step_level <= 1'b0;
            level_prev <= 1'b0;
            step_count <= 16'h0000;
        end else begin
            s1         <= step_btn;
            s2         <= s1;
            level_prev <= step_level;
            if (s2 == step_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                step_level <= s2;
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
            if (step_pulse) begin
                step_count <= step_count + 16'd1;
            end
        end
    end

    // Digit refresh timer, frame snapshot and registered display drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_cnt   <= '0;
            idx      <= 2'd0;
            frame    <= 16'h0000;
            frame_pc <= 1'b0;
            an       <= 4'b1111;
            seg      <= 7'h7F;
            dp       <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= hex_code(nibble);
            dp  <= ~(frame_pc & (idx == 2'd0));
            if (rf_cnt == RF_LAST) begin
                rf_cnt <= '0;
                idx    <= idx + 2'd1;
                if (idx == 2'd3) begin
                    frame    <= src_half;
                    frame_pc <= sel_pc;
                end
            end else begin
                rf_cnt <= rf_cnt + RF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl with DEBOUNCE_CYCLES=4,
// REFRESH_CYCLES=3: directed scenarios plus a randomized run, all compared
// against a window/arithmetic reference model.
module tb_seg_display_ctrl;

    localparam int D = 4;
    localparam int R = 3;
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        reset;
    logic        step_btn;
    logic        sel_pc;
    logic        half_sel;
    logic [31:0] pc_in;
    logic [31:0] reg_in;
    logic        step_level;
    logic        step_pulse;
    logic [15:0] step_count;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    seg_display_ctrl #(.DEBOUNCE_CYCLES(D), .REFRESH_CYCLES(R)) dut (
        .clk        (clk),
        .reset      (reset),
        .step_btn   (step_btn),
        .sel_pc     (sel_pc),
        .half_sel   (half_sel),
        .pc_in      (pc_in),
        .reg_in     (reg_in),
        .step_level (step_level),
        .step_pulse (step_pulse),
        .step_count (step_count),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: n = clock edges since reset; the level flips when the
    // last D synchronised samples all disagree with it; the display index is
    // n/R mod 4 and the frame is the value presented at the last multiple of 4R.
    int          n;
    bit          hist[$];
    bit          syncq[$];
    bit          m_level, m_prev, all_diff;
    logic [15:0] m_count;
    logic [15:0] m_frame;
    bit          m_fpc;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    bit          e_dp;
    int          idx_old;
    logic [31:0] word;
    logic [3:0]  nib;

    always @(posedge clk) begin
        if (reset) begin
            n = 0;
            hist.delete();
            syncq.delete();
            m_level = 0; m_prev = 0; m_count = 16'h0;
            m_frame = 16'h0; m_fpc = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1;
        end else begin
            n++;
            idx_old = ((n - 1) / R) % 4;
            nib     = m_frame[4*idx_old +: 4];
            e_an    = ~(4'b0001 << idx_old);
            e_seg   = HEX[nib];
            e_dp    = !(m_fpc && idx_old == 0);
            if (n % (4 * R) == 0) begin
                word    = sel_pc ? pc_in : reg_in;
                m_frame = half_sel ? word[31:16] : word[15:0];
                m_fpc   = sel_pc;
            end
            if (m_level && !m_prev) m_count = m_count + 16'd1;
            m_prev = m_level;
            syncq.push_back(n >= 3 ? hist[n-3] : 1'b0);
            if (syncq.size() >= D) begin
                all_diff = 1;
                for (int j = 0; j < D; j++)
                    if (syncq[syncq.size()-1-j] == m_level) all_diff = 0;
                if (all_diff) m_level = !m_level;
            end
            hist.push_back(step_btn);
        end
    end

    // Every cycle, all outputs are compared with the model.
    always @(negedge clk) begin
        check("model_level", step_level, m_level);
        check("model_pulse", step_pulse, m_level & ~m_prev);
        check("model_count", step_count, m_count);
        check("model_an",    an,  e_an);
        check("model_seg",   seg, e_seg);
        check("model_dp",    dp,  e_dp);
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    int pulses, first, ever_high, run_len;
    bit btn_val;

    initial begin
        reset = 1; step_btn = 0; sel_pc = 0; half_sel = 0;
        pc_in = 32'h0; reg_in = 32'h1234ABCD;
        repeat (2) tick();
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_count", step_count, 16'h0);
        check("rst_level", step_level, 1'b0);
        reset = 0;
        tick();
        check("first_an", an, 4'b1110);
        check("first_seg", seg, 7'h40);
        check("first_dp", dp, 1'b1);
        check("first_count", step_count, 16'h0);

        // Register mode: first frame latched at edge 12, shown from edge 13.
        repeat (12) tick();
        check("reg_an0", an, 4'b1110); check("reg_seg0", seg, 7'h21); check("reg_dp0", dp, 1'b1);
        repeat (3) tick();
        check("reg_an1", an, 4'b1101); check("reg_seg1", seg, 7'h46); check("reg_dp1", dp, 1'b1);
        repeat (3) tick();
        check("reg_an2", an, 4'b1011); check("reg_seg2", seg, 7'h03); check("reg_dp2", dp, 1'b1);
        repeat (3) tick();
        check("reg_an3", an, 4'b0111); check("reg_seg3", seg, 7'h08); check("reg_dp3", dp, 1'b1);

        // Clean press and release.
        step_btn = 1; pulses = 0; first = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (step_pulse) pulses++;
            if (step_level && first == 0) first = i;
        end
        check("press_latency", first, 6);
        check("press_pulses", pulses, 1);
        check("press_count", step_count, 16'd1);
        step_btn = 0; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step_pulse) pulses++;
        end
        check("release_level", step_level, 1'b0);
        check("release_pulses", pulses, 0);
        check("release_count", step_count, 16'd1);

        // Bounce never reaches D stable samples.
        pulses = 0; ever_high = 0;
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 4; j++) begin
                step_btn = (j != 3);
                tick();
                if (step_pulse) pulses++;
                if (step_level) ever_high = 1;
            end
        check("bounce_level", ever_high, 0);
        check("bounce_pulses", pulses, 0);
        step_btn = 1; pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step_pulse) pulses++;
        end
        check("stable_pulses", pulses, 1);
        step_btn = 0;
        repeat (10) tick();
        check("stable_count", step_count, 16'd2);

        // PC mode and frame atomicity.
        for (int i = 0; i < 12 && (n % 12) != 0; i++) tick();
        check("align_frame", n % 12, 0);
        sel_pc = 1; half_sel = 1; pc_in = 32'h00400010;
        repeat (12) tick();
        tick();
        check("pc_an0", an, 4'b1110); check("pc_seg0", seg, 7'h40); check("pc_dp0", dp, 1'b0);
        tick();
        half_sel = 0;
        repeat (2) tick();
        check("pc_an1", an, 4'b1101); check("pc_seg1", seg, 7'h19); check("pc_dp1", dp, 1'b1);
        repeat (3) tick();
        check("pc_an2", an, 4'b1011); check("pc_seg2", seg, 7'h40);
        repeat (3) tick();
        check("pc_an3", an, 4'b0111); check("pc_seg3", seg, 7'h40);
        repeat (6) tick();
        check("pc_next_an1", an, 4'b1101); check("pc_next_seg1", seg, 7'h79);

        // Randomized run; the model checks every cycle.
        btn_val = 0; run_len = 0;
        for (int i = 0; i < 1500; i++) begin
            if (run_len == 0) begin
                btn_val = ~btn_val;
                run_len = $urandom_range(1, 9);
            end
            run_len--;
            step_btn = btn_val;
            if ($urandom_range(0, 19) == 0) begin
                sel_pc = $urandom_range(0, 1);
                half_sel = $urandom_range(0, 1);
                pc_in = $urandom;
                reg_in = $urandom;
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 0;

        // Counter wrap via preload.
        step_btn = 0;
        repeat (10) tick();
        force dut.step_count = 16'hFFFF;
        release dut.step_count;
        m_count = 16'hFFFF;
        tick();
        check("wrap_pre", step_count, 16'hFFFF);
        step_btn = 1; pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step_pulse) pulses++;
        end
        check("wrap_pulses", pulses, 1);
        check("wrap_count", step_count, 16'h0000);
        step_btn = 0;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
